// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
//   Shared definitions for the instruction-fetch stage.
//   - fetch_state_e : fetch controller states
//       FETCH : idle / issuing; a request goes out whenever the queue has room
//       WAIT  : a request is outstanding and its data will be kept
//       DRAIN : a request is outstanding but was overtaken by a redirect; its
//               data is thrown away when the ack arrives
//   - INSTR_BYTES   : byte size of one instruction word (PC increment)
// -----------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

endpackage : if_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Circular FIFO of {pc, instruction} pairs between the fetch controller and
//   decode. Flush has priority over push and pop in the same cycle. Pointers
//   wrap modulo DEPTH (power of two). Head data comes straight from registered
//   storage.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   flush       in   empty the queue, cancelling any same-cycle push/pop
//   push        in   write {push_pc, push_instr} at the tail
//   push_pc     in   PC of the word being written
//   push_instr  in   instruction word being written
//   pop         in   drop the head entry (ignored when empty)
//   full        out  count == DEPTH
//   empty       out  count == 0
//   count       out  number of valid entries
//   head_pc     out  PC of the head entry (undefined when empty)
//   head_instr  out  instruction of the head entry (undefined when empty)
// -----------------------------------------------------------------------------
module fetch_queue
    import if_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [ADDR_WIDTH-1:0]  push_pc,
    input  logic [INSTR_WIDTH-1:0] push_instr,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       count,
    output logic [ADDR_WIDTH-1:0]  head_pc,
    output logic [INSTR_WIDTH-1:0] head_instr
);

    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic push_en;
    logic pop_en;

    assign push_en = push & ~flush;
    assign pop_en  = pop & ~flush & ~empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: natural pointer overflow is the wrap.
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only observable after
    // it has been written, and count/pointers already define validity.
    always_ff @(posedge clock) begin
        if (push_en) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule : fetch_queue

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch stage. Owns the PC, fetches from a variable-latency
//   instruction memory over a req/ack handshake (at most one request in
//   flight) and buffers fetched words in fetch_queue for decode. A redirect
//   flushes the queue, reloads the PC and discards any in-flight fetch.
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   branch_taken    in   redirect request (pulse or held)
//   branch_address  in   redirect target; bits [1:0] forced to 0
//   imem_req        out  fetch request, held until imem_ack
//   imem_addr       out  fetch address, stable while a request is pending
//   imem_ack        in   fetch complete; imem_rdata valid this cycle
//   imem_rdata      in   fetched instruction word
//   out_valid       out  queue head valid
//   out_ready       in   decode accepts the head
//   instruction     out  head instruction (0 when empty)
//   pc_value        out  head PC + 4 (0 when empty)
// -----------------------------------------------------------------------------
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    localparam int                   CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_address,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  pc_value
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INSTR_BYTES - 1));

    fetch_state_e          state;
    fetch_state_e          state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_nxt;
    logic [ADDR_WIDTH-1:0] drain_addr;
    logic [ADDR_WIDTH-1:0] drain_addr_nxt;

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  req_int;
    logic                  q_push;
    logic                  q_pop;
    logic                  q_full;
    logic                  q_empty;
    logic [CNT_W-1:0]      q_count;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [INSTR_WIDTH-1:0] head_instr;

    assign pc_plus4      = pc + PC_STEP;
    assign branch_target = branch_address & ALIGN_MASK;

    // ------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------
    fetch_queue #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (QUEUE_DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (branch_taken),
        .push       (q_push),
        .push_pc    (pc),
        .push_instr (imem_rdata),
        .pop        (q_pop),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign out_valid = (q_count != '0);
    assign q_pop     = out_valid & out_ready;

    // Zero the head fields when empty so decode never sees stale storage.
    assign instruction = q_empty ? '0 : head_instr;
    assign pc_value    = q_empty ? '0 : (head_pc + PC_STEP);

    // ------------------------------------------------------------------
    // Fetch controller: next state, PC, drain address, push
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        req_int        = 1'b0;
        q_push         = 1'b0;

        // Issue only on space left before this cycle's pop; once a request
        // is out it stays up until acked.
        case (state)
            FETCH:       req_int = ~q_full;
            WAIT, DRAIN: req_int = 1'b1;
            default:     req_int = 1'b0;
        endcase

        if (branch_taken) begin
            // Redirect wins: the queue flushes itself, any ack this cycle is
            // dropped, and a still-pending request must be drained.
            pc_nxt = branch_target;
            if (req_int && !imem_ack) begin
                state_nxt = DRAIN;
                // Already draining: the pending address is drain_addr, keep it.
                if (state != DRAIN) drain_addr_nxt = pc;
            end else begin
                state_nxt = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (req_int) begin
                        if (imem_ack) begin
                            q_push = 1'b1;
                            pc_nxt = pc_plus4;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        q_push    = 1'b1;
                        pc_nxt    = pc_plus4;
                        state_nxt = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
        end
    end

    // Request is forced low while reset is held, not just after the edge.
    assign imem_req  = req_int & reset;
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

endmodule : if_fetch_queue

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//   Self-checking bench for if_fetch_queue. The reference model tracks the
//   instruction queue as a SV queue of {pc, instr}, the current PC, and the
//   single in-flight fetch (address plus a "discard on arrival" flag). The
//   bench plays imem with a configurable ack latency and returns
//   addr ^ 32'hA5A5A5A5 as data.
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;

    localparam int          AW     = 32;
    localparam int          IW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] DATA_X = 32'hA5A5A5A5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_address = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] instruction;
    logic [AW-1:0] pc_value;

    always #5 clock = ~clock;

    if_fetch_queue #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RST_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction    (instruction),
        .pc_value       (pc_value)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } entry_t;

    entry_t        m_q[$];
    logic [AW-1:0] m_pc;
    logic          m_busy;
    logic [AW-1:0] m_busy_addr;
    logic          m_discard;

    // imem responder
    logic          r_active;
    int            r_remaining;
    int            lat_min;
    int            lat_max;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc        = RST_PC;
        m_busy      = 1'b0;
        m_busy_addr = '0;
        m_discard   = 1'b0;
        r_active    = 1'b0;
        r_remaining = 0;
    endtask

    // Hold reset low for n cycles (checking outputs as soon as it drops),
    // then release on a falling edge.
    task automatic do_reset(input int n);
        @(negedge clock);
        reset        = 1'b0;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        out_ready    = 1'b0;
        model_reset();
        #1;
        check("rst_imem_req", 64'(imem_req), 64'(1'b0));
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_instruction", 64'(instruction), 64'h0);
        check("rst_pc_value", 64'(pc_value), 64'h0);
        repeat (n) @(negedge clock);
        reset = 1'b1;
    endtask

    // One clock cycle: drive inputs on the falling edge, compare outputs 1 time
    // unit later, then advance the model to its post-edge state. Returns
    // before the rising edge, so callers may inspect this cycle's outputs.
    task automatic cycle(input logic br, input logic [AW-1:0] baddr, input logic rdy);
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic          ack;
        logic          pop;
        logic [IW-1:0] data;
        logic [AW-1:0] exp_pcv;
        logic [IW-1:0] exp_instr;

        @(negedge clock);
        exp_req  = m_busy ? 1'b1 : (m_q.size() < DEPTH);
        exp_addr = m_busy ? m_busy_addr : m_pc;
        ack      = 1'b0;
        if (exp_req) begin
            if (!r_active) begin
                r_active    = 1'b1;
                r_remaining = $urandom_range(lat_max, lat_min);
            end
            ack = (r_remaining == 0);
        end
        data = ack ? (exp_addr ^ DATA_X) : IW'($urandom);

        branch_taken   = br;
        branch_address = baddr;
        out_ready      = rdy;
        imem_ack       = ack;
        imem_rdata     = data;
        #1;

        if (m_q.size() != 0) begin
            exp_instr = m_q[0].instr;
            exp_pcv   = m_q[0].pc + 32'd4;
        end else begin
            exp_instr = '0;
            exp_pcv   = '0;
        end
        check("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req) check("imem_addr", 64'(imem_addr), 64'(exp_addr));
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        check("instruction", 64'(instruction), 64'(exp_instr));
        check("pc_value", 64'(pc_value), 64'(exp_pcv));

        // model update
        pop = (m_q.size() != 0) && rdy;
        if (br) begin
            m_q.delete();
            m_pc = baddr & ~32'h3;
            if (exp_req && !ack) begin
                m_busy      = 1'b1;
                m_busy_addr = exp_addr;
                m_discard   = 1'b1;
            end else begin
                m_busy    = 1'b0;
                m_discard = 1'b0;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (exp_req && ack) begin
                if (!(m_busy && m_discard)) begin
                    m_q.push_back('{pc: exp_addr, instr: data});
                    m_pc = exp_addr + 32'd4;
                end
                m_busy    = 1'b0;
                m_discard = 1'b0;
            end else if (exp_req && !m_busy) begin
                m_busy      = 1'b1;
                m_busy_addr = exp_addr;
                m_discard   = 1'b0;
            end
        end

        if (ack) r_active = 1'b0;
        else if (exp_req) r_remaining--;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] baddr;
        model_reset();
        reset = 1'b0;

        // --- 1: streaming with same-cycle ack ---
        lat_min = 0; lat_max = 0;
        do_reset(3);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t1_instr0", 64'(instruction), 64'hA5A5A5A5);
        check("t1_pcv0", 64'(pc_value), 64'h4);
        cycle(1'b0, '0, 1'b1);
        check("t1_instr1", 64'(instruction), 64'hA5A5A5A1);
        check("t1_pcv1", 64'(pc_value), 64'h8);
        repeat (5) cycle(1'b0, '0, 1'b1);

        // --- 2: back-pressure fills the queue, then drains ---
        do_reset(2);
        repeat (4) cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("t2_full_req", 64'(imem_req), 64'(1'b0));
        check("t2_full_valid", 64'(out_valid), 64'(1'b1));
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("t2_pop_cycle_req", 64'(imem_req), 64'(1'b0));
        cycle(1'b0, '0, 1'b1);
        check("t2_refill_req", 64'(imem_req), 64'(1'b1));
        check("t2_refill_addr", 64'(imem_addr), 64'h10);
        repeat (6) cycle(1'b0, '0, 1'b1);

        // --- 3: redirect while waiting on a slow ack ---
        lat_min = 3; lat_max = 3;
        do_reset(2);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h100, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t3_held_addr", 64'(imem_addr), 64'h0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t3_new_addr", 64'(imem_addr), 64'h100);
        check("t3_no_valid", 64'(out_valid), 64'(1'b0));
        repeat (3) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t3_instr", 64'(instruction), 64'hA5A5A4A5);
        check("t3_pcv", 64'(pc_value), 64'h104);

        // --- 4: redirect with a pop and an ack in the same cycle ---
        lat_min = 0; lat_max = 0;
        do_reset(2);
        repeat (3) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 32'h200, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("t4_flushed", 64'(out_valid), 64'(1'b0));
        check("t4_addr", 64'(imem_addr), 64'h200);
        repeat (3) cycle(1'b0, '0, 1'b1);

        // --- 5: target alignment and PC wrap ---
        do_reset(2);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h103, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t5_aligned", 64'(imem_addr), 64'h100);
        cycle(1'b1, 32'hFFFFFFFC, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("t5_top_addr", 64'(imem_addr), 64'hFFFFFFFC);
        cycle(1'b0, '0, 1'b1);
        check("t5_wrap_addr", 64'(imem_addr), 64'h0);
        check("t5_wrap_pcv", 64'(pc_value), 64'h0);
        check("t5_wrap_instr", 64'(instruction), 64'h5A5A5A59);
        repeat (3) cycle(1'b0, '0, 1'b1);

        // --- 6: reset during WAIT with two queued entries ---
        do_reset(2);
        repeat (2) cycle(1'b0, '0, 1'b0);
        lat_min = 3; lat_max = 3;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("t6_wait_valid", 64'(out_valid), 64'(1'b1));
        do_reset(2);
        lat_min = 0; lat_max = 0;
        cycle(1'b0, '0, 1'b1);
        check("t6_restart_addr", 64'(imem_addr), 64'(RST_PC));
        repeat (3) cycle(1'b0, '0, 1'b1);

        // --- randomized traffic against the model ---
        lat_min = 0; lat_max = 3;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                baddr = 32'hFFFFFFF0 | AW'($urandom_range(0, 15));
            else
                baddr = AW'($urandom);
            cycle(($urandom_range(0, 15) == 0), baddr, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_fetch_queue
